// File: rtl/operand_pkg.sv
// Operand pair types shared by the operand FIFO and the downstream compare stage.
package operand_pkg;

  localparam int OPERAND_WIDTH = 16;

  typedef struct packed {
    logic [OPERAND_WIDTH-1:0] a;
    logic [OPERAND_WIDTH-1:0] b;
  } operand_pair_t;

endpackage

// File: rtl/operand_fifo_mem.sv
// Operand pair storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module operand_fifo_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/operand_fifo.sv
// Operand pair FIFO feeding the compare stage; pointers, occupancy, flush and drop logic.
// Build option OPERAND_FIFO_DROP_CNT_EN adds a saturating drop_cnt output.
module operand_fifo
  import operand_pkg::*;
#(
  parameter int WIDTH = OPERAND_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_a,
  output logic [WIDTH-1:0]       out_b,
  output logic [$clog2(DEPTH):0] count
`ifdef OPERAND_FIFO_DROP_CNT_EN
  ,
  output logic [15:0]            drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_last;
  logic [2*WIDTH-1:0] w_head;
  logic [2*WIDTH-1:0] w_shown;
  logic               w_push;
  logic               w_pop;

  assign in_ready  = (r_count != CW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  operand_fifo_mem #(
    .DATA_W (2*WIDTH),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_push && !flush),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data ({in_a, in_b}),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // When empty the read slot is stale, so the outputs replay whatever was shown last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_last <= '0;
    else        r_last <= w_shown;
  end

  assign w_shown = out_valid ? w_head : r_last;
  assign out_a   = w_shown[2*WIDTH-1:WIDTH];
  assign out_b   = w_shown[WIDTH-1:0];
  assign count   = r_count;

`ifdef OPERAND_FIFO_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        r_drop_cnt <= '0;
    else if (flush)                                    r_drop_cnt <= '0;
    else if (in_valid && !in_ready && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 1'b1;
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule
